// File: rtl/distance_table_if.sv
// Command and response bus of the distance table.
// The master side issues table commands and search requests; the slave side
// returns read data, relax acknowledgements and minimum-search results.
interface distance_table_if #(
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 8
);
  logic                   get_en;
  logic                   set_en;
  logic                   relax_en;
  logic                   visit_en;
  logic [INDEX_WIDTH-1:0] index;
  logic [VALUE_WIDTH-1:0] wr_value;
  logic                   find_start;

  logic [VALUE_WIDTH-1:0] rd_value;
  logic                   rd_valid;
  logic                   relax_updated;
  logic                   min_busy;
  logic                   min_done;
  logic                   min_found;
  logic [INDEX_WIDTH-1:0] min_index;
  logic [VALUE_WIDTH-1:0] min_value;
  logic                   all_visited;

  modport master (
    output get_en, set_en, relax_en, visit_en, index, wr_value, find_start,
    input  rd_value, rd_valid, relax_updated, min_busy, min_done, min_found,
           min_index, min_value, all_visited
  );

  modport slave (
    input  get_en, set_en, relax_en, visit_en, index, wr_value, find_start,
    output rd_value, rd_valid, relax_updated, min_busy, min_done, min_found,
           min_index, min_value, all_visited
  );
endinterface

// File: rtl/distance_table.sv
// Distance table for shortest-path engines.
// Holds one distance and one visited flag per node, supports read, write,
// relax (store only if strictly smaller) and visit commands, and runs a
// sequential scan that finds the unvisited node with the smallest distance.
module distance_table #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 4,
  parameter int VALUE_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] src_index_i,
  distance_table_if.slave        bus
);

  localparam logic [VALUE_WIDTH-1:0] INFINITY = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  logic [VALUE_WIDTH-1:0] table_q [MAX_NODES];
  logic [MAX_NODES-1:0]   visited_q;

  state_t                 state_q;
  logic [INDEX_WIDTH-1:0] scanPtr_q;
  logic [VALUE_WIDTH-1:0] bestValue_q;
  logic [INDEX_WIDTH-1:0] bestIndex_q;
  logic                   bestFound_q;
  logic [VALUE_WIDTH-1:0] bestValue_d;
  logic [INDEX_WIDTH-1:0] bestIndex_d;
  logic                   bestFound_d;

  logic [VALUE_WIDTH-1:0] rdValue_q;
  logic                   rdValid_q;
  logic                   relaxUpdated_q;
  logic                   minBusy_q;
  logic                   minDone_q;
  logic                   minFound_q;
  logic [INDEX_WIDTH-1:0] minIndex_q;
  logic [VALUE_WIDTH-1:0] minValue_q;

  logic                   indexInRange;
  logic [VALUE_WIDTH-1:0] storedValue;
  logic                   cmdAllowed;
  logic                   doSet;
  logic                   doRelax;
  logic                   doVisit;
  logic                   lastEntry;

  assign indexInRange = 32'(bus.index) < 32'(MAX_NODES);
  assign storedValue  = indexInRange ? table_q[bus.index] : INFINITY;
  assign cmdAllowed   = (state_q == IDLE);
  assign lastEntry    = 32'(scanPtr_q) == 32'(MAX_NODES - 1);

  // Resolve command priority: set beats relax beats visit, all blocked while searching
  always_comb begin
    doSet   = 1'b0;
    doRelax = 1'b0;
    doVisit = 1'b0;
    if (cmdAllowed && indexInRange) begin
      if (bus.set_en) begin
        doSet = 1'b1;
      end else if (bus.relax_en) begin
        doRelax = (bus.wr_value < storedValue);
      end else if (bus.visit_en) begin
        doVisit = 1'b1;
      end
    end
  end

  // Distance entries and visited flags; reset seeds the source node with zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        table_q[i] <= (int'(src_index_i) == i) ? '0 : INFINITY;
      end
      visited_q <= '0;
    end else begin
      if (doSet || doRelax) begin
        table_q[bus.index] <= bus.wr_value;
      end
      if (doVisit) begin
        visited_q[bus.index] <= 1'b1;
      end
    end
  end

  // Read port and relax acknowledge, both one cycle after the request
  always_ff @(posedge clock) begin
    if (reset) begin
      rdValue_q      <= '0;
      rdValid_q      <= 1'b0;
      relaxUpdated_q <= 1'b0;
    end else begin
      rdValid_q      <= bus.get_en;
      relaxUpdated_q <= doRelax;
      if (bus.get_en) begin
        rdValue_q <= storedValue;
      end
    end
  end

  // Candidate evaluation for the entry under the scan pointer
  always_comb begin
    bestValue_d = bestValue_q;
    bestIndex_d = bestIndex_q;
    bestFound_d = bestFound_q;
    if (!visited_q[scanPtr_q] && (table_q[scanPtr_q] < bestValue_q)) begin
      bestValue_d = table_q[scanPtr_q];
      bestIndex_d = scanPtr_q;
      bestFound_d = 1'b1;
    end
  end

  // Minimum-search FSM, one entry per cycle, results held until the next search ends
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      scanPtr_q   <= '0;
      bestValue_q <= INFINITY;
      bestIndex_q <= '0;
      bestFound_q <= 1'b0;
      minBusy_q   <= 1'b0;
      minDone_q   <= 1'b0;
      minFound_q  <= 1'b0;
      minIndex_q  <= '0;
      minValue_q  <= INFINITY;
    end else begin
      case (state_q)
        IDLE: begin
          minDone_q <= 1'b0;
          if (bus.find_start) begin
            state_q     <= SCAN;
            scanPtr_q   <= '0;
            bestValue_q <= INFINITY;
            bestIndex_q <= '0;
            bestFound_q <= 1'b0;
            minBusy_q   <= 1'b1;
          end
        end
        SCAN: begin
          bestValue_q <= bestValue_d;
          bestIndex_q <= bestIndex_d;
          bestFound_q <= bestFound_d;
          if (lastEntry) begin
            state_q    <= DONE;
            minDone_q  <= 1'b1;
            minFound_q <= bestFound_d;
            minIndex_q <= bestFound_d ? bestIndex_d : '0;
            minValue_q <= bestValue_d;
          end else begin
            scanPtr_q <= scanPtr_q + 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          minDone_q <= 1'b0;
          minBusy_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          minBusy_q <= 1'b0;
          minDone_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_value      = rdValue_q;
  assign bus.rd_valid      = rdValid_q;
  assign bus.relax_updated = relaxUpdated_q;
  assign bus.min_busy      = minBusy_q;
  assign bus.min_done      = minDone_q;
  assign bus.min_found     = minFound_q;
  assign bus.min_index     = minIndex_q;
  assign bus.min_value     = minValue_q;
  assign bus.all_visited   = &visited_q;

endmodule

// File: tb/tb_distance_table.sv
// Self-checking bench for distance_table with a 4-node table.
module tb_distance_table;

  localparam int MAX_NODES   = 4;
  localparam int INDEX_WIDTH = 2;
  localparam int VALUE_WIDTH = 8;
  localparam int INF         = 255;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [INDEX_WIDTH-1:0] srcIndex;

  distance_table_if #(.INDEX_WIDTH(INDEX_WIDTH), .VALUE_WIDTH(VALUE_WIDTH)) bus ();

  distance_table #(
    .MAX_NODES  (MAX_NODES),
    .INDEX_WIDTH(INDEX_WIDTH),
    .VALUE_WIDTH(VALUE_WIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .src_index_i(srcIndex),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int g;
    int s;
    int r;
    int v;
    int idx;
    int val;
    int expRdValid;
    int expRdValue;
    int expRelax;
  } vec_t;

  vec_t vecs[$];

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int model[MAX_NODES];
  int vis[MAX_NODES];
  int busyCnt;
  int expRdValid, expRdValue, expRelax, expDone, expBusy;
  int expFound, expIndex, expValue;
  int pendFound, pendIndex, pendValue;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void addVec(int g, int s, int r, int v, int idx, int val,
                                 int erv, int erd, int er);
    vec_t t;
    t.g = g; t.s = s; t.r = r; t.v = v; t.idx = idx; t.val = val;
    t.expRdValid = erv; t.expRdValue = erd; t.expRelax = er;
    vecs.push_back(t);
  endfunction

  task automatic modelReset(input int src);
    for (int i = 0; i < MAX_NODES; i++) begin
      model[i] = (i == src) ? 0 : INF;
      vis[i]   = 0;
    end
    busyCnt = 0; expBusy = 0; expDone = 0; expRelax = 0;
    expRdValid = 0; expRdValue = 0;
    expFound = 0; expIndex = 0; expValue = INF;
  endtask

  // Smallest reachable unvisited distance, lowest index among equals
  task automatic computeSearch(output int found, output int idx, output int val);
    int minVal;
    minVal = INF;
    for (int i = 0; i < MAX_NODES; i++)
      if (vis[i] == 0 && model[i] < minVal) minVal = model[i];
    found = (minVal < INF) ? 1 : 0;
    val   = minVal;
    idx   = 0;
    if (found != 0) begin
      for (int i = MAX_NODES - 1; i >= 0; i--)
        if (vis[i] == 0 && model[i] == minVal) idx = i;
    end
  endtask

  task automatic applyStimulus(input int g, input int s, input int r, input int v,
                               input int idx, input int val, input int f);
    @(negedge clock);
    bus.get_en     = (g != 0);
    bus.set_en     = (s != 0);
    bus.relax_en   = (r != 0);
    bus.visit_en   = (v != 0);
    bus.index      = INDEX_WIDTH'(idx);
    bus.wr_value   = VALUE_WIDTH'(val);
    bus.find_start = (f != 0);
    expRdValid = g;
    if (g != 0) expRdValue = model[idx];
    expRelax = 0;
    expDone  = 0;
    if (busyCnt == 0) begin
      if (s != 0) model[idx] = val;
      else if (r != 0) begin
        if (val < model[idx]) begin
          model[idx] = val;
          expRelax = 1;
        end
      end else if (v != 0) vis[idx] = 1;
      if (f != 0) begin
        computeSearch(pendFound, pendIndex, pendValue);
        busyCnt = MAX_NODES + 1;
      end
    end else begin
      busyCnt--;
      if (busyCnt == 1) begin
        expDone  = 1;
        expFound = pendFound;
        expIndex = pendIndex;
        expValue = pendValue;
      end
    end
    expBusy = (busyCnt > 0) ? 1 : 0;
    @(posedge clock);
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset(input int src);
    @(negedge clock);
    reset = 1'b1;
    srcIndex = INDEX_WIDTH'(src);
    bus.get_en = 1'b0; bus.set_en = 1'b0; bus.relax_en = 1'b0; bus.visit_en = 1'b0;
    bus.find_start = 1'b0; bus.index = '0; bus.wr_value = '0;
    @(posedge clock);
    #1;
    modelReset(src);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic checkModel(input string tag);
    int allVis;
    allVis = 1;
    for (int i = 0; i < MAX_NODES; i++) if (vis[i] == 0) allVis = 0;
    checkOutput({tag, " rd_valid"}, 32'(bus.rd_valid), expRdValid);
    if (expRdValid != 0) checkOutput({tag, " rd_value"}, 32'(bus.rd_value), expRdValue);
    checkOutput({tag, " relax_updated"}, 32'(bus.relax_updated), expRelax);
    checkOutput({tag, " min_busy"}, 32'(bus.min_busy), expBusy);
    checkOutput({tag, " min_done"}, 32'(bus.min_done), expDone);
    checkOutput({tag, " min_found"}, 32'(bus.min_found), expFound);
    checkOutput({tag, " min_index"}, 32'(bus.min_index), expIndex);
    checkOutput({tag, " min_value"}, 32'(bus.min_value), expValue);
    checkOutput({tag, " all_visited"}, 32'(bus.all_visited), allVis);
  endtask

  task automatic waitDone(input string tag, output int lat);
    lat = 1;
    while (bus.min_done !== 1'b1 && lat < 20) begin
      applyIdle();
      lat++;
    end
    checkOutput({tag, " latency"}, lat, MAX_NODES + 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    reset = 1'b0;
    srcIndex = '0;
    bus.get_en = 1'b0; bus.set_en = 1'b0; bus.relax_en = 1'b0; bus.visit_en = 1'b0;
    bus.find_start = 1'b0; bus.index = '0; bus.wr_value = '0;

    // Vector table starting from a reset with source node 2
    addVec(1, 0, 0, 0, 0, 0,   1, 255, 0);
    addVec(1, 0, 0, 0, 1, 0,   1, 255, 0);
    addVec(1, 0, 0, 0, 2, 0,   1, 0,   0);
    addVec(1, 0, 0, 0, 3, 0,   1, 255, 0);
    addVec(1, 0, 1, 0, 1, 10,  1, 255, 1);
    addVec(1, 0, 1, 0, 1, 12,  1, 10,  0);
    addVec(0, 0, 1, 0, 1, 7,   0, 0,   1);
    addVec(1, 0, 0, 0, 1, 0,   1, 7,   0);
    addVec(1, 0, 1, 0, 1, 7,   1, 7,   0);
    addVec(1, 1, 1, 0, 1, 2,   1, 7,   0);
    addVec(1, 0, 0, 0, 1, 0,   1, 2,   0);
    addVec(0, 0, 1, 1, 3, 50,  0, 0,   1);
    addVec(1, 0, 0, 0, 3, 0,   1, 50,  0);
    addVec(0, 1, 0, 1, 0, 5,   0, 0,   0);
    addVec(1, 0, 0, 0, 0, 0,   1, 5,   0);

    doReset(2);
    checkOutput("reset rd_value", 32'(bus.rd_value), 0);
    checkOutput("reset rd_valid", 32'(bus.rd_valid), 0);
    checkOutput("reset relax_updated", 32'(bus.relax_updated), 0);
    checkOutput("reset min_busy", 32'(bus.min_busy), 0);
    checkOutput("reset min_done", 32'(bus.min_done), 0);
    checkOutput("reset min_found", 32'(bus.min_found), 0);
    checkOutput("reset min_index", 32'(bus.min_index), 0);
    checkOutput("reset min_value", 32'(bus.min_value), INF);
    checkOutput("reset all_visited", 32'(bus.all_visited), 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].g, vecs[i].s, vecs[i].r, vecs[i].v, vecs[i].idx, vecs[i].val, 0);
      checkOutput($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), vecs[i].expRdValid);
      if (vecs[i].expRdValid != 0)
        checkOutput($sformatf("vec%0d rd_value", i), 32'(bus.rd_value), vecs[i].expRdValue);
      checkOutput($sformatf("vec%0d relax_updated", i), 32'(bus.relax_updated), vecs[i].expRelax);
    end
    checkOutput("visits dropped by priority", 32'(bus.all_visited), 0);

    // Search with a tie between nodes 0 and 3, node 2 visited
    applyStimulus(0, 1, 0, 0, 1, 200, 0);
    applyStimulus(0, 1, 0, 0, 3, 5, 0);
    applyStimulus(0, 0, 0, 1, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("search A busy", 32'(bus.min_busy), 1);
    waitDone("search A", lat);
    checkOutput("search A found", 32'(bus.min_found), 1);
    checkOutput("search A index", 32'(bus.min_index), 0);
    checkOutput("search A value", 32'(bus.min_value), 5);
    applyIdle();
    checkOutput("search A done pulse width", 32'(bus.min_done), 0);
    checkOutput("search A busy released", 32'(bus.min_busy), 0);

    // Write coinciding with find_start commits first; writes while busy are dropped
    applyStimulus(0, 1, 0, 0, 3, 1, 1);
    applyStimulus(0, 1, 0, 0, 1, 3, 1);
    lat = 2;
    while (bus.min_done !== 1'b1 && lat < 20) begin
      applyIdle();
      lat++;
    end
    checkOutput("search B latency", lat, MAX_NODES + 1);
    checkOutput("search B index", 32'(bus.min_index), 3);
    checkOutput("search B value", 32'(bus.min_value), 1);
    applyIdle();
    applyIdle();
    checkOutput("search B result held", 32'(bus.min_index), 3);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("busy set dropped", 32'(bus.rd_value), 200);

    // Every node visited
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 3, 0, 0);
    checkOutput("all_visited set", 32'(bus.all_visited), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    waitDone("search C", lat);
    checkOutput("search C found", 32'(bus.min_found), 0);
    checkOutput("search C index", 32'(bus.min_index), 0);
    checkOutput("search C value", 32'(bus.min_value), INF);

    // Reset two cycles into a scan aborts it
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyIdle();
    applyIdle();
    doReset(1);
    checkOutput("abort min_busy", 32'(bus.min_busy), 0);
    checkOutput("abort min_done", 32'(bus.min_done), 0);
    for (int i = 0; i < 6; i++) begin
      applyIdle();
      checkOutput($sformatf("abort no done %0d", i), 32'(bus.min_done), 0);
    end
    for (int i = 0; i < MAX_NODES; i++) begin
      applyStimulus(1, 0, 0, 0, i, 0, 0);
      checkOutput($sformatf("abort reinit node%0d", i), 32'(bus.rd_value), (i == 1) ? 0 : INF);
    end
    checkOutput("abort visited cleared", 32'(bus.all_visited), 0);

    // Randomised traffic against the reference model
    doReset(int'($urandom_range(0, 3)));
    for (int n = 0; n < 400; n++) begin
      int g, s, r, v, f, idx, val;
      if (n == 200) doReset(int'($urandom_range(0, 3)));
      g   = ($urandom_range(0, 99) < 50) ? 1 : 0;
      s   = ($urandom_range(0, 99) < 15) ? 1 : 0;
      r   = ($urandom_range(0, 99) < 40) ? 1 : 0;
      v   = ($urandom_range(0, 99) < 6)  ? 1 : 0;
      f   = ($urandom_range(0, 99) < 8)  ? 1 : 0;
      idx = int'($urandom_range(0, 3));
      val = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 255));
      applyStimulus(g, s, r, v, idx, val, f);
      checkModel($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
